// File: rtl/labfinal_soc_keys_pio.sv
`default_nettype none
// ============================================================================
//  Module   : labfinal_soc_keys_pio
//  Purpose  : Memory-mapped input PIO for keys/switches. Asynchronous inputs
//             pass through a two-flop synchronizer and an optional per-bit
//             debounce filter. Rising edges of the filtered value are latched
//             into an edge-capture register, which raises a level interrupt
//             through a programmable mask.
//  Options  : `define LABFINAL_SOC_KEYS_PIO_DEBOUNCE_EN selects the debounce
//             filter. When it is undefined, the filtered value is the
//             synchronized value delayed by one register.
//  Ports    : clk        - single clock; all state updates on its rising edge
//             reset_n    - synchronous active-low reset
//             address    - register select (0 data, 1 unused, 2 mask, 3 edge)
//             chipselect - bus access qualifier
//             write_n    - active-low write strobe
//             writedata  - 32-bit write data
//             in_port    - asynchronous external inputs, WIDTH bits
//             readdata   - combinational, zero-extended read data
//             irq        - level interrupt, |(edge_capture & irq_mask)
//  Revision : 1.0 - initial release
// ============================================================================
module labfinal_soc_keys_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_NONE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] s1_q,           s1_d;
  logic [WIDTH-1:0] s2_q,           s2_d;
  logic [WIDTH-1:0] f_q,            f_d;
  logic [WIDTH-1:0] f_prev_q,       f_prev_d;
  logic [WIDTH-1:0] irq_mask_q,     irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] wr_clear;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // --------------------------------------------------------------------------
  // Synchronizer and edge pipeline next-state
  // --------------------------------------------------------------------------
  always_comb begin
    s1_d     = in_port;
    s2_d     = s1_q;
    f_prev_d = f_q;
  end

  // --------------------------------------------------------------------------
  // Filter stage: f follows s2 either directly (one register) or after a
  // per-bit run of DEBOUNCE_CYCLES consecutive differing samples.
  // --------------------------------------------------------------------------
`ifdef LABFINAL_SOC_KEYS_PIO_DEBOUNCE_EN
  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_bit_d;

    // The counter only runs while the synchronized input disagrees with the
    // filtered value; any agreement (a glitch ending) restarts the run.
    always_comb begin
      cnt_d   = '0;
      f_bit_d = f_q[i];
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q == CNT_LAST) begin
          f_bit_d = s2_q[i];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign f_d[i] = f_bit_d;
  end : g_debounce
`else
  assign f_d = s2_q;

  // DEBOUNCE_CYCLES only shapes the filter; keep it referenced in this build.
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
`endif

  // --------------------------------------------------------------------------
  // Edge capture and interrupt mask
  // --------------------------------------------------------------------------
  always_comb begin
    rise = f_q & ~f_prev_q;

    wr_clear = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      wr_clear = writedata[WIDTH-1:0];
    end

    // A new rise is OR-ed in after the clear so it is never lost to a
    // coincident write-one-to-clear.
    edge_capture_d = (edge_capture_q & ~wr_clear) | rise;

    irq_mask_d = irq_mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q           <= '0;
      s2_q           <= '0;
      f_q            <= '0;
      f_prev_q       <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      f_q            <= f_d;
      f_prev_q       <= f_prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  // --------------------------------------------------------------------------
  // Zero wait-state read path; chipselect does not gate it.
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(f_q);
      ADDR_NONE: readdata = '0;
      ADDR_MASK: readdata = 32'(irq_mask_q);
      ADDR_EDGE: readdata = 32'(edge_capture_q);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

  // Only the low WIDTH bits of writedata carry register content.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule : labfinal_soc_keys_pio
`default_nettype wire
